segre_mem_req_arbiter: RTL and testbench

//  Parametrised N-channel successor to the fixed ICACHE/DCACHE memory arbiter. Round-robin grants

---
 rtl/segre_pkg.sv | 20 ++
 rtl/segre_sync_fifo.sv | 55 +++++
 rtl/segre_mem_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_segre_mem_req_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and default sizing for the N-channel memory request arbiter.
package segre_pkg;

  localparam int unsigned MEM_ARB_NUM_CH    = 4;
  localparam int unsigned MEM_ARB_BUF_DEPTH = 16;
  localparam int unsigned MEM_ARB_MAX_OUTST = 4;
  localparam int unsigned MEM_ARB_ADDR_W    = 32;
  localparam int unsigned MEM_ARB_LINE_BITS = 128;
  // Wide enough for up to 16 requesters.
  localparam int unsigned MEM_ARB_CH_ID_W   = 4;

  typedef struct packed {
    logic                         rd;
    logic                         wr;
    logic [MEM_ARB_ADDR_W-1:0]    addr;
    logic [MEM_ARB_LINE_BITS-1:0] line;
    logic [MEM_ARB_CH_ID_W-1:0]   ch_id;
  } arb_mem_req_t;

endpackage

// File: rtl/segre_sync_fifo.sv
// Synchronous FIFO with registered storage, entry count and full/empty flags.
module segre_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [PtrW:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    do_push = push_i & (~full_o | do_pop);
    wptr_d  = wptr_q + PtrW'(do_push);
    rptr_d  = rptr_q + PtrW'(do_pop);
    cnt_d   = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/segre_mem_req_arbiter.sv
// Round-robin N-channel arbiter into a request FIFO towards memory, with in-order routing of
// read responses back to the requesting channel.
module segre_mem_req_arbiter
  import segre_pkg::*;
#(
  parameter int unsigned NUM_CH    = MEM_ARB_NUM_CH,
  parameter int unsigned BUF_DEPTH = MEM_ARB_BUF_DEPTH,
  parameter int unsigned MAX_OUTST = MEM_ARB_MAX_OUTST,
  parameter int unsigned ADDR_W    = MEM_ARB_ADDR_W,
  parameter int unsigned LINE_BITS = MEM_ARB_LINE_BITS
) (
  input  logic                        clk_i,
  input  logic                        rsn_i,
  input  logic [NUM_CH-1:0]           req_valid_i,
  output logic [NUM_CH-1:0]           req_ready_o,
  input  logic [NUM_CH-1:0]           req_rd_i,
  input  logic [NUM_CH-1:0]           req_wr_i,
  input  logic [NUM_CH*ADDR_W-1:0]    req_addr_i,
  input  logic [NUM_CH*LINE_BITS-1:0] req_line_i,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output arb_mem_req_t                mem_req_o,
  input  logic                        mem_rsp_valid_i,
  input  logic [LINE_BITS-1:0]        mem_rsp_line_i,
  output logic [NUM_CH-1:0]           rsp_valid_o,
  output logic [LINE_BITS-1:0]        rsp_line_o,
  output logic [$clog2(BUF_DEPTH):0]  occupancy_o,
  output logic                        err_o
);

  localparam int unsigned ChW     = $clog2(NUM_CH);
  localparam int unsigned ReqW    = $bits(arb_mem_req_t);
  localparam int unsigned OutstCW = $clog2(MAX_OUTST) + 1;

  logic [ChW-1:0] rr_q, rr_d;
  logic [ChW-1:0] grant_idx;
  logic           grant_valid;
  logic           err_q, err_d;

  logic           req_full, req_empty, req_pop;
  arb_mem_req_t   push_req, head_req;
  logic [ReqW-1:0] head_raw;

  logic                       outst_full, outst_empty, outst_push, outst_pop;
  logic [MEM_ARB_CH_ID_W-1:0] outst_id;
  logic [OutstCW-1:0]         outst_cnt_unused;

  // Round-robin search starting at the pointer; no grant at all while the FIFO is full.
  always_comb begin
    logic [ChW:0] sum;
    logic [ChW-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    if (!req_full) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sum = {1'b0, rr_q} + (ChW+1)'(i);
        if (sum >= (ChW+1)'(NUM_CH)) begin
          sum = sum - (ChW+1)'(NUM_CH);
        end
        idx = sum[ChW-1:0];
        if (!grant_valid && req_valid_i[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    push_req       = '0;
    push_req.ch_id = MEM_ARB_CH_ID_W'(grant_idx);
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      req_ready_o[k] = grant_valid && (grant_idx == ChW'(k));
      if (grant_idx == ChW'(k)) begin
        push_req.rd   = req_rd_i[k];
        push_req.wr   = req_wr_i[k];
        push_req.addr = req_addr_i[k*ADDR_W +: ADDR_W];
        push_req.line = req_line_i[k*LINE_BITS +: LINE_BITS];
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_valid) begin
      rr_d = (grant_idx == ChW'(NUM_CH - 1)) ? '0 : grant_idx + ChW'(1);
    end
  end

  segre_sync_fifo #(
    .Width (ReqW),
    .Depth (BUF_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .push_i  (grant_valid),
    .data_i  (push_req),
    .pop_i   (req_pop),
    .data_o  (head_raw),
    .count_o (occupancy_o),
    .full_o  (req_full),
    .empty_o (req_empty)
  );

  assign head_req        = arb_mem_req_t'(head_raw);
  assign mem_req_o       = head_req;
  // A read at the head waits until there is room to remember who asked for it.
  assign mem_req_valid_o = ~req_empty & ~(head_req.rd & outst_full);
  assign req_pop         = mem_req_valid_o & mem_req_ready_i;
  assign outst_push      = req_pop & head_req.rd;
  assign outst_pop       = mem_rsp_valid_i & ~outst_empty;

  segre_sync_fifo #(
    .Width (MEM_ARB_CH_ID_W),
    .Depth (MAX_OUTST)
  ) u_outst_fifo (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .push_i  (outst_push),
    .data_i  (head_req.ch_id),
    .pop_i   (outst_pop),
    .data_o  (outst_id),
    .count_o (outst_cnt_unused),
    .full_o  (outst_full),
    .empty_o (outst_empty)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      rsp_valid_o[k] = outst_pop && (outst_id == MEM_ARB_CH_ID_W'(k));
    end
  end

  assign rsp_line_o = mem_rsp_line_i;
  assign err_d      = err_q | (mem_rsp_valid_i & outst_empty);
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_segre_mem_req_arbiter.sv
// Randomized scoreboard bench for the memory request arbiter against a queue-based model.
module tb_segre_mem_req_arbiter;
  import segre_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int BUF = 16;
  localparam int OUT = 4;

  logic             clk = 1'b0;
  logic             rsn;
  logic [NCH-1:0]   req_valid, req_ready, req_rd, req_wr;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*LW-1:0] req_line;
  logic             mem_req_valid, mem_req_ready, mem_rsp_valid;
  arb_mem_req_t     mem_req;
  logic [LW-1:0]    mem_rsp_line, rsp_line;
  logic [NCH-1:0]   rsp_valid;
  logic [4:0]       occupancy;
  logic             err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  arb_mem_req_t req_q[$];
  int           outst_q[$];
  int           rr = 0;
  bit           m_err = 1'b0;
  bit           granted_last [NCH];

  segre_mem_req_arbiter dut (
    .clk_i           (clk),
    .rsn_i           (rsn),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_rd_i        (req_rd),
    .req_wr_i        (req_wr),
    .req_addr_i      (req_addr),
    .req_line_i      (req_line),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_o       (mem_req),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_line_i  (mem_rsp_line),
    .rsp_valid_o     (rsp_valid),
    .rsp_line_o      (rsp_line),
    .occupancy_o     (occupancy),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are compared at the falling edge; the model then advances as the DUT will
  // at the next rising edge.
  always @(negedge clk) begin
    if (!rsn) begin
      req_q.delete();
      outst_q.delete();
      rr    = 0;
      m_err = 1'b0;
      for (int k = 0; k < NCH; k++) granted_last[k] = 1'b0;
      chk("rst_occupancy", 256'(occupancy), 256'(0));
      chk("rst_mem_valid", 256'(mem_req_valid), 256'(0));
      chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    end else begin
      int             exp_k;
      logic [NCH-1:0] exp_rdy, exp_rsp;
      bit             exp_mv;
      arb_mem_req_t   e;

      chk("occupancy", 256'(occupancy), 256'(req_q.size()));
      chk("err", 256'(err), 256'(m_err));

      exp_k = -1;
      if (req_q.size() < BUF) begin
        for (int i = 0; i < NCH; i++) begin
          if (exp_k < 0 && req_valid[(rr + i) % NCH]) exp_k = (rr + i) % NCH;
        end
      end
      exp_rdy = '0;
      if (exp_k >= 0) exp_rdy[exp_k] = 1'b1;
      chk("grant", 256'(req_ready), 256'(exp_rdy));

      exp_mv = (req_q.size() > 0) && !(req_q[0].rd && outst_q.size() >= OUT);
      chk("mem_req_valid", 256'(mem_req_valid), 256'(exp_mv));

      exp_rsp = '0;
      if (mem_rsp_valid) begin
        if (outst_q.size() > 0) begin
          exp_rsp[outst_q.pop_front()] = 1'b1;
          chk("rsp_line", 256'(rsp_line), 256'(mem_rsp_line));
        end else begin
          m_err = 1'b1;
        end
      end
      chk("rsp_valid", 256'(rsp_valid), 256'(exp_rsp));

      if (exp_mv && mem_req_ready) begin
        chk("mem_req", 256'(mem_req), 256'(req_q[0]));
        if (req_q[0].rd) outst_q.push_back(int'(req_q[0].ch_id));
        void'(req_q.pop_front());
      end

      for (int k = 0; k < NCH; k++) granted_last[k] = (exp_k == k);
      if (exp_k >= 0) begin
        e.rd    = req_rd[exp_k];
        e.wr    = req_wr[exp_k];
        e.addr  = req_addr[exp_k*AW +: AW];
        e.line  = req_line[exp_k*LW +: LW];
        e.ch_id = 4'(exp_k);
        req_q.push_back(e);
        rr = (exp_k + 1) % NCH;
      end
    end
  end

  task automatic drive(input int pv, input int pr, input int prsp, input bit force_rsp);
    int r;
    for (int k = 0; k < NCH; k++) begin
      // Requesters hold valid and payload until granted.
      if (!req_valid[k] || granted_last[k]) begin
        req_valid[k] = ($urandom_range(99) < pv);
        r = $urandom_range(9);
        req_rd[k] = (r < 5) || (r == 9);
        req_wr[k] = (r >= 5);
        req_addr[k*AW +: AW] = $urandom;
        req_line[k*LW +: LW] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    mem_req_ready = ($urandom_range(99) < pr);
    mem_rsp_line  = {$urandom, $urandom, $urandom, $urandom};
    mem_rsp_valid = force_rsp || (outst_q.size() > 0 && $urandom_range(99) < prsp);
  endtask

  task automatic run(input int cycles, input int pv, input int pr, input int prsp);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      drive(pv, pr, prsp, 1'b0);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rsn = 1'b0;
    req_valid = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rsn = 1'b1;
  endtask

  initial begin
    rsn = 1'b0;
    req_valid = '0;
    req_rd = '0;
    req_wr = '0;
    req_addr = '0;
    req_line = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_line = '0;
    repeat (3) @(posedge clk);
    #1;
    rsn = 1'b1;

    run(40, 100, 100, 100);   // all channels busy: strict rotation
    run(40, 100, 0, 100);     // memory stalled: FIFO fills, grants stop
    run(60, 100, 100, 0);     // no responses: outstanding limit blocks head reads
    run(1500, 60, 60, 40);    // mixed random traffic
    run(40, 80, 50, 10);
    do_reset(2);              // reset with requests queued and reads outstanding
    run(10, 100, 100, 0);     // rotation restarts at channel 0
    run(40, 0, 100, 100);     // drain everything

    // Response with nothing outstanding
    @(posedge clk);
    #1;
    drive(0, 100, 0, outst_q.size() == 0);
    run(10, 50, 100, 50);
    do_reset(2);
    run(5, 0, 100, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
